// File: rtl/booth_seq_mult_pkg.sv
// Shared constants for the sequential Booth multiplier: FSM state codes and Booth op-codes.
// Also provides a helper that maps the {Q[0], q_1} pair to an op-code.
package booth_seq_mult_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] BOOTH_NOP = 2'd0;
    localparam logic [1:0] BOOTH_ADD = 2'd1;
    localparam logic [1:0] BOOTH_SUB = 2'd2;

    function automatic logic [1:0] booth_op(input logic q0, input logic q_1);
        logic [1:0] op;
        case ({q0, q_1})
            2'b01:   op = BOOTH_ADD;
            2'b10:   op = BOOTH_SUB;
            default: op = BOOTH_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_seq_mult_step.sv
// One radix-2 Booth step: conditional add/subtract of M into A, then an arithmetic
// right shift of {A, Q, q_1} by one bit. Purely combinational.
module booth_seq_mult_step
    import booth_seq_mult_pkg::*;
#(
    parameter int unsigned E = 9
) (
    input  logic [E:0]   a_i,
    input  logic [E-1:0] q_i,
    input  logic         q_1_i,
    input  logic [E-1:0] m_i,
    output logic [E:0]   a_o,
    output logic [E-1:0] q_o,
    output logic         q_1_o
);

    logic [E:0] m_ext;
    logic [E:0] sum;
    logic [1:0] op;

    // A carries one guard bit so that A - M never overflows, even for M = most negative.
    assign m_ext = {m_i[E-1], m_i};
    assign op    = booth_op(q_i[0], q_1_i);

    always_comb begin
        sum = a_i;
        case (op)
            BOOTH_ADD: sum = a_i + m_ext;
            BOOTH_SUB: sum = a_i - m_ext;
            default:   sum = a_i;
        endcase
    end

    assign a_o   = {sum[E], sum[E:1]};
    assign q_o   = {sum[0], q_i[E-1:1]};
    assign q_1_o = q_i[0];

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier, one step per clock, signed or unsigned per operation.
// Operands are widened to WIDTH+1 bits so a single signed Booth product covers both modes.
module booth_seq_mult
    import booth_seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    localparam int unsigned E  = WIDTH + 1;
    localparam int unsigned CW = $clog2(E);

    logic [1:0]         state_q, state_d;
    logic [E-1:0]       m_q, m_d;
    logic [E:0]         a_q, a_d;
    logic [E-1:0]       q_q, q_d;
    logic               q1_q, q1_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] p_q, p_d;

    logic [E-1:0] x_ext, y_ext;
    logic [E:0]   a_nx;
    logic [E-1:0] q_nx;
    logic         q1_nx;

    assign x_ext = is_signed ? {x[WIDTH-1], x} : {1'b0, x};
    assign y_ext = is_signed ? {y[WIDTH-1], y} : {1'b0, y};

    booth_seq_mult_step #(
        .E (E)
    ) u_step (
        .a_i   (a_q),
        .q_i   (q_q),
        .q_1_i (q1_q),
        .m_i   (m_q),
        .a_o   (a_nx),
        .q_o   (q_nx),
        .q_1_o (q1_nx)
    );

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        a_d     = a_q;
        q_d     = q_q;
        q1_d    = q1_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    m_d     = x_ext;
                    q_d     = y_ext;
                    a_d     = '0;
                    q1_d    = 1'b0;
                    cnt_d   = CW'(E - 1);
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_d  = a_nx;
                q_d  = q_nx;
                q1_d = q1_nx;
                if (cnt_q == '0) begin
                    // Product is captured on the final step so it is valid while done is high.
                    p_d     = {a_nx[WIDTH-2:0], q_nx};
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            m_q     <= '0;
            a_q     <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            a_q     <= a_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    assign ready = (state_q == ST_IDLE);
    assign busy  = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign done  = (state_q == ST_DONE);
    assign p     = p_q;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Scoreboard bench for booth_seq_mult (WIDTH=8): the driver pushes expected products,
// a monitor pops and compares on every done pulse, also checking latency and p stability.
module tb_booth_seq_mult;

    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic           is_signed;
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic           ready;
    logic           busy;
    logic           done;
    logic [2*W-1:0] p;

    booth_seq_mult #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .x         (x),
        .y         (y),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .p         (p)
    );

    typedef struct {
        logic [2*W-1:0] p;
        int             c0;
        string          name;
    } exp_t;

    exp_t           sb[$];
    int             n_tests = 0;
    int             n_fail  = 0;
    int             cyc     = 0;
    logic [2*W-1:0] last_p  = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_p = '0;
        end else if (done) begin
            chk("done_ready_exclusive", 32'(ready), 32'd0);
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_done: got done with p=0x%0h, required no done", p);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_p"}, 32'(p), 32'(e.p));
                chk({e.name, "_latency"}, 32'(cyc - e.c0), 32'(W + 2));
            end
            last_p = p;
        end else if (p !== last_p) begin
            chk("p_stable", 32'(p), 32'(last_p));
            last_p = p;
        end
    end

    task automatic issue(input string name, input logic s, input logic [W-1:0] xv,
                         input logic [W-1:0] yv, input logic [2*W-1:0] ev);
        bit got;
        exp_t e;
        got = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ready) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            chk({name, "_ready_timeout"}, 32'd0, 32'd1);
            return;
        end
        is_signed = s;
        x         = xv;
        y         = yv;
        start     = 1'b1;
        e.p    = ev;
        e.c0   = cyc;
        e.name = name;
        sb.push_back(e);
        @(negedge clk);
        start     = 1'b0;
        // Scramble inputs after acceptance; latched operands must be unaffected.
        x         = ~xv;
        y         = ~yv;
        is_signed = ~s;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        chk({name, "_drained"}, 32'(sb.size()), 32'd0);
    endtask

    typedef struct {
        string          name;
        logic           s;
        logic [W-1:0]   xv;
        logic [W-1:0]   yv;
        logic [2*W-1:0] ev;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2*W-1:0] xe, ye;
        logic [2*W-1:0] model;
        vecs = '{
            '{"s_m128_m128", 1'b1, 8'h80, 8'h80, 16'h4000},
            '{"s_m128_127",  1'b1, 8'h80, 8'h7F, 16'hC080},
            '{"u_255_255",   1'b0, 8'hFF, 8'hFF, 16'hFE01},
            '{"u_0_200",     1'b0, 8'h00, 8'hC8, 16'h0000},
            '{"u_1_255",     1'b0, 8'h01, 8'hFF, 16'h00FF},
            '{"s_m1_m1",     1'b1, 8'hFF, 8'hFF, 16'h0001},
            '{"s_127_127",   1'b1, 8'h7F, 8'h7F, 16'h3F01},
            '{"s_m1_1",      1'b1, 8'hFF, 8'h01, 16'hFFFF},
            '{"u_128_128",   1'b0, 8'h80, 8'h80, 16'h4000},
            '{"u_200_3",     1'b0, 8'hC8, 8'h03, 16'h0258},
            '{"s_0_m128",    1'b1, 8'h00, 8'h80, 16'h0000},
            '{"s_m5_9",      1'b1, 8'hFB, 8'h09, 16'hFFD3}
        };

        rst_n     = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        x         = '0;
        y         = '0;
        #1;
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_busy",  32'(busy),  32'd0);
        chk("reset_done",  32'(done),  32'd0);
        chk("reset_p",     32'(p),     32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors issued back to back.
        foreach (vecs[i]) issue(vecs[i].name, vecs[i].s, vecs[i].xv, vecs[i].yv, vecs[i].ev);
        wait_drain("directed");

        // start pulsed while busy must be ignored.
        issue("busy_start", 1'b1, 8'd3, 8'd5, 16'd15);
        start     = 1'b1;
        x         = 8'd7;
        y         = 8'd7;
        is_signed = 1'b1;
        @(negedge clk);
        chk("busy_start_not_ready", 32'(ready), 32'd0);
        start = 1'b0;
        wait_drain("busy_start");

        // Reset mid-operation aborts with no done pulse.
        issue("abort", 1'b1, 8'hFB, 8'h09, 16'hFFD3);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_busy",  32'(busy),  32'd0);
        chk("abort_done",  32'(done),  32'd0);
        chk("abort_p",     32'(p),     32'd0);
        void'(sb.pop_back());
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        issue("restart_m5_9", 1'b1, 8'hFB, 8'h09, 16'hFFD3);
        wait_drain("restart");

        // Random vectors against a plain truncated-multiply model.
        for (int i = 0; i < 200; i++) begin
            logic         s;
            logic [W-1:0] xv, yv;
            s  = 1'($urandom_range(0, 1));
            xv = W'($urandom);
            yv = W'($urandom);
            xe = s ? {{W{xv[W-1]}}, xv} : {{W{1'b0}}, xv};
            ye = s ? {{W{yv[W-1]}}, yv} : {{W{1'b0}}, yv};
            model = xe * ye;
            issue("random", s, xv, yv, model);
        end
        wait_drain("random");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
